// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and valid/ready result wrapper around a registered 16-bit ALU.
// Define ALU_SEQ_FLAGS_EN to add zero/negative/overflow result flags.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [2:0]             in_op,
    output logic [W-1:0]           alu_a,
    output logic [W-1:0]           alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_en,
    input  logic [W-1:0]           alu_result,
    input  logic                   alu_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_result,
    output logic                   out_cout,
    output logic [2:0]             out_op,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic                   out_ovf
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]    mem_a  [DEPTH];
    logic [W-1:0]    mem_b  [DEPTH];
    logic [2:0]      mem_op [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            issue;
    logic            vld_p1;
    logic [2:0]      op_p1;

    // Stage p0: FIFO head presented straight to the ALU inputs
    assign in_ready = (fifo_count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign issue    = (fifo_count != '0) && (!vld_p1 || out_ready);
    assign alu_en   = issue;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (fifo_count != '0) begin
            alu_a  = mem_a[rd_ptr];
            alu_b  = mem_b[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Stage p1: ALU result register doubles as the output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
        end else if (issue) begin
            vld_p1 <= 1'b1;
            op_p1  <= alu_op;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_op     = op_p1;
    assign out_result = alu_result;
    assign out_cout   = alu_cout;

`ifdef ALU_SEQ_FLAGS_EN
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    logic signed [W-1:0] a_p1;
    logic signed [W-1:0] b_p1;

    function automatic logic ovf_flag(input logic [2:0] op,
                                      input logic signed [W-1:0] a,
                                      input logic signed [W-1:0] b,
                                      input logic signed [W-1:0] r);
        case (op)
            OP_ADD:  ovf_flag = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            OP_SUB:  ovf_flag = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            default: ovf_flag = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_p1 <= '0;
            b_p1 <= '0;
        end else if (issue) begin
            a_p1 <= alu_a;
            b_p1 <= alu_b;
        end
    end

    assign out_zero = (alu_result == '0);
    assign out_neg  = alu_result[W-1];
    assign out_ovf  = ovf_flag(op_p1, a_p1, b_p1, alu_result);
`endif

endmodule
